// File: rtl/vga_pattern_sequencer_if.sv
// Connects the pattern sequencer to the timing generator, the raw buttons and the renderer.
// master drives pixel position and buttons; slave is the sequencer.
interface vga_pattern_sequencer_if;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       btn_next_n;
    logic       btn_mode_n;
    logic [2:0] pattern_sel;
    logic       pattern_update;
    logic       auto_mode;
    logic [6:0] frame_count;

    modport master (
        output pixel_x, pixel_y, btn_next_n, btn_mode_n,
        input  pattern_sel, pattern_update, auto_mode, frame_count
    );

    modport slave (
        input  pixel_x, pixel_y, btn_next_n, btn_mode_n,
        output pattern_sel, pattern_update, auto_mode, frame_count
    );
endinterface

// File: rtl/vga_pattern_sequencer.sv
// Chooses the VGA test pattern: auto-advances every FRAMES_PER_PATTERN frames or steps on a button press.
// Pattern changes are applied only on the first pixel of vertical blanking.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_AUTO   | frame_tick counted; terminal count or pending press steps
//   S_MANUAL | frame_count held at 0; only a pending press steps
module vga_pattern_sequencer #(
    parameter int H_VIDEO            = 640,
    parameter int V_VIDEO            = 480,
    parameter int NUM_PATTERNS       = 8,
    parameter int FRAMES_PER_PATTERN = 120,
    parameter int DEBOUNCE_CYCLES    = 250000,
    parameter bit AUTO_AT_RESET      = 1'b1
) (
    input  logic                  clk_0,
    input  logic                  rst,
    vga_pattern_sequencer_if.slave bus
);

    if (H_VIDEO < 1 || V_VIDEO < 1 || V_VIDEO > 1023 || NUM_PATTERNS < 2 || NUM_PATTERNS > 8 ||
        FRAMES_PER_PATTERN < 1 || FRAMES_PER_PATTERN > 128 || DEBOUNCE_CYCLES < 2) begin : g_bad_params
        $error("vga_pattern_sequencer: parameter out of range");
    end

    localparam int              DB_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]      SEL_LAST = 3'(NUM_PATTERNS - 1);
    localparam logic [6:0]      FC_LAST  = 7'(FRAMES_PER_PATTERN - 1);
    localparam logic [9:0]      V_BLANK  = 10'(V_VIDEO);

    typedef enum logic {
        S_MANUAL = 1'b0,
        S_AUTO   = 1'b1
    } state_t;

    localparam state_t S_RESET = AUTO_AT_RESET ? S_AUTO : S_MANUAL;

    state_t          state;
    state_t          state_next;
    logic [1:0]      btn_raw;
    logic [1:0]      btn_meta;
    logic [1:0]      btn_sync;
    logic [1:0]      btn_level;
    logic [1:0]      btn_press;
    logic [DB_W-1:0] db_cnt [2];
    logic            next_press;
    logic            mode_press;
    logic            frame_tick;
    logic            step;
    logic            pending;
    logic            auto_mode;
    logic            at_terminal;
    logic [2:0]      pattern_sel;
    logic            pattern_update;
    logic [6:0]      frame_count;

    // index 0 = next button, index 1 = mode button
    assign btn_raw    = {bus.btn_mode_n, bus.btn_next_n};
    assign next_press = btn_press[0];
    assign mode_press = btn_press[1];

    // Synchronisers reset to the released level so leaving reset never looks like a press.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            btn_meta  <= 2'b11;
            btn_sync  <= 2'b11;
            btn_level <= 2'b11;
            btn_press <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
            for (int i = 0; i < 2; i++) begin
                btn_press[i] <= 1'b0;
                if (btn_sync[i] != btn_level[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        btn_level[i] <= btn_sync[i];
                        btn_press[i] <= ~btn_sync[i];
                        db_cnt[i]    <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk_0) begin
        if (!rst) begin
            state <= S_RESET;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_AUTO:   if (mode_press) state_next = S_MANUAL;
            S_MANUAL: if (mode_press) state_next = S_AUTO;
            default:  state_next = S_RESET;
        endcase
    end

    always_comb begin
        auto_mode   = 1'b0;
        at_terminal = 1'b0;
        case (state)
            S_AUTO: begin
                auto_mode   = 1'b1;
                at_terminal = (frame_count == FC_LAST);
            end
            default: ;
        endcase
    end

    assign frame_tick = (bus.pixel_x == 10'd0) && (bus.pixel_y == V_BLANK);
    assign step       = frame_tick && (pending || at_terminal);

    // A next press landing on a tick cycle survives the step and waits for the following tick.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            pattern_sel    <= '0;
            pattern_update <= 1'b0;
            pending        <= 1'b0;
            frame_count    <= '0;
        end else begin
            pattern_update <= step;
            if (step) begin
                pattern_sel <= (pattern_sel == SEL_LAST) ? 3'd0 : pattern_sel + 3'd1;
            end
            if (next_press) begin
                pending <= 1'b1;
            end else if (step) begin
                pending <= 1'b0;
            end
            if (mode_press || !auto_mode || next_press || step) begin
                frame_count <= '0;
            end else if (frame_tick && frame_count != FC_LAST) begin
                frame_count <= frame_count + 7'd1;
            end
        end
    end

    assign bus.pattern_sel    = pattern_sel;
    assign bus.pattern_update = pattern_update;
    assign bus.auto_mode      = auto_mode;
    assign bus.frame_count    = frame_count;

endmodule
